aes_shiftrow_pipe: RTL

Registered, handshaked Rijndael ShiftRows/InvShiftRows stage, parametrised in block width (Nb = 4, 6 or 8 columns). It sits between the SubBytes and MixColumns stages of the round datapath behind the eFPGA interface. The mode (forward/inverse) and a sideband tag are selected per beat. A two-entry output/skid buffer sustains one block per cycle under back-pressure.

---
 rtl/aes_shiftrow_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/aes_shiftrow_pipe.sv
// Registered Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake.
// A main entry plus one skid entry let the stage take one beat per cycle under back-pressure.
module aes_shiftrow_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [32*NB-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [32*NB-1:0] out
);

  localparam int unsigned W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shiftrow_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W == 0) begin : g_bad_tag
    $error("aes_shiftrow_pipe: TAG_W must be at least 1");
  end

  // Rows 2 and 3 shift one position further in the 256-bit block.
  function automatic int row_off(input int row);
    return (NB == 8 && row >= 2) ? row + 1 : row;
  endfunction

  logic [W-1:0] fwd_sr;
  logic [W-1:0] inv_sr;
  logic [W-1:0] beat_data;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int Off  = row_off(r);
      localparam int FwdC = (c + Off) % NB;
      localparam int InvC = (c + NB - Off) % NB;
      localparam int Dst  = W - 1 - 8 * (4 * c + r);
      assign fwd_sr[Dst -: 8] = in[W - 1 - 8 * (4 * FwdC + r) -: 8];
      assign inv_sr[Dst -: 8] = in[W - 1 - 8 * (4 * InvC + r) -: 8];
    end
  end

  assign beat_data = in_inv ? inv_sr : fwd_sr;

  logic             main_valid_q, main_valid_d;
  logic [W-1:0]     main_data_q, main_data_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             accept;
  logic             main_free;

  // in_ready comes only from registered state, never from out_ready.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign main_free = !main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = beat_data;
        main_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new beat in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = beat_data;
      skid_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out       = main_data_q;
  assign out_tag   = main_tag_q;

  a_skid_needs_main: assert property (@(posedge clk) disable iff (rst)
    skid_valid_q |-> main_valid_q);

  a_stall_holds: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready && !flush |=> out_valid && $stable(out) && $stable(out_tag));

  a_no_accept_when_full: assert property (@(posedge clk) disable iff (rst)
    skid_valid_q |-> !accept);

endmodule
